// File: rtl/uart_rx_oversampled_if.sv
// Receiver-side bundle for uart_rx_oversampled: tick/line inputs, frame result outputs.
// The parity_err_o member exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_oversampled_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick_i;
    logic                 rx_i;
    logic [DATA_BITS-1:0] data_o;
    logic                 rx_done_o;
    logic                 frame_err_o;
    logic                 busy_o;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err_o;
`endif

    modport master (
        input  tick_i,
        input  rx_i,
        output data_o,
        output rx_done_o,
        output frame_err_o,
`ifdef UART_RX_PARITY_EN
        output parity_err_o,
`endif
        output busy_o
    );

    modport slave (
        output tick_i,
        output rx_i,
        input  data_o,
        input  rx_done_o,
        input  frame_err_o,
`ifdef UART_RX_PARITY_EN
        input  parity_err_o,
`endif
        input  busy_o
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// UART receiver driven by an OVERSAMPLE-x tick; LSB-first, mid-bit sampling, framing check.
// Optional parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
`ifdef UART_RX_PARITY_EN
    parameter int PARITY_ODD = 0,
`endif
    parameter int SB_TICKS   = 16
) (
    input  logic                    clock,
    input  logic                    reset_i,
    uart_rx_oversampled_if.master   bus
);
    localparam int TICK_MAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
    localparam int TW       = $clog2(TICK_MAX);
    localparam int BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICKS - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 done_d;
    logic                 rx_meta, rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
`endif

    // Synchroniser resets to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset_i) begin
        if (!reset_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx_i;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        done_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                end
            end
            S_START: begin
                if (bus.tick_i) begin
                    if (tick_cnt_q == MID_START) begin
                        if (!rx_s) begin
                            state_d    = S_DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (bus.tick_i) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bus.tick_i) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        par_d      = rx_s;
                        tick_cnt_d = '0;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (bus.tick_i) begin
                    if (tick_cnt_q == STOP_LAST) begin
                        done_d     = 1'b1;
                        tick_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o = (state_q != S_IDLE);
    end

    // Result registers update only on the completing tick and hold until the next frame.
    always_ff @(posedge clock or negedge reset_i) begin
        if (!reset_i) begin
            bus.data_o      <= '0;
            bus.rx_done_o   <= 1'b0;
            bus.frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            bus.parity_err_o <= 1'b0;
`endif
        end else begin
            bus.rx_done_o <= done_d;
            if (done_d) begin
                bus.data_o      <= shreg_q;
                bus.frame_err_o <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                bus.parity_err_o <= par_q ^ (^shreg_q) ^ PARITY_ODD[0];
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: 10 MHz clock, tick every 65 clocks, 1040 clocks per bit.
// Frames are serialised from plain byte values; results are compared to a queue of expected frames.
module tb_uart_rx_oversampled;
    localparam int BIT     = 1040;
    localparam int TICKDIV = 65;
    localparam int BADSTOP = 800;

    logic clock;
    logic reset_i;
    int   tdiv;

    uart_rx_oversampled_if #(.DATA_BITS(8)) bus ();

    uart_rx_oversampled #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .SB_TICKS  (16)
    ) dut (
        .clock  (clock),
        .reset_i(reset_i),
        .bus    (bus.master)
    );

    initial clock = 1'b0;
    always #50 clock = ~clock;

    initial tdiv = 0;
    always @(posedge clock) begin
        if (tdiv == TICKDIV - 1) begin
            tdiv       <= 0;
            bus.tick_i <= 1'b1;
        end else begin
            tdiv       <= tdiv + 1;
            bus.tick_i <= 1'b0;
        end
    end

    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;
    int         done_cnt = 0;
    int         long_cnt = 0;
    logic       prev_done = 1'b0;
    logic [7:0] rec_data[$];
    logic       rec_ferr[$];
    logic       rec_perr[$];

    always @(negedge clock) begin
        if (bus.rx_done_o === 1'b1) begin
            done_cnt++;
            if (prev_done) long_cnt++;
            rec_data.push_back(bus.data_o);
            rec_ferr.push_back(bus.frame_err_o);
`ifdef UART_RX_PARITY_EN
            rec_perr.push_back(bus.parity_err_o);
`else
            rec_perr.push_back(1'b0);
`endif
        end
        prev_done = bus.rx_done_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Serialise one frame: start, LSB-first data, optional parity, stop held for stop_len clocks.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v,
                              input int stop_len);
        logic [7:0] v;
        v = d;
        bus.rx_i = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rx_i = v[i];
            wait_clk(BIT);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx_i = par_v;
        wait_clk(BIT);
`else
        if (par_v) bus.rx_i = 1'b1;
`endif
        bus.rx_i = stop_v;
        wait_clk(stop_len);
        bus.rx_i = 1'b1;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp_d, input logic exp_ferr);
        check({tag, "_data"}, 32'(rec_data[$]), 32'(exp_d));
        check({tag, "_ferr"}, 32'(rec_ferr[$]), 32'(exp_ferr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(bus.data_o), 32'h0);
        check({tag, "_done"}, 32'(bus.rx_done_o), 32'h0);
        check({tag, "_ferr"}, 32'(bus.frame_err_o), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy_o), 32'h0);
`ifdef UART_RX_PARITY_EN
        check({tag, "_perr"}, 32'(bus.parity_err_o), 32'h0);
`endif
    endtask

    initial begin
        int         base;
        logic [7:0] rd;
        logic       rstop;

        reset_i  = 1'b0;
        bus.rx_i = 1'b1;
        wait_clk(3);
        check_reset_outputs("reset");
        reset_i = 1'b1;
        wait_clk(200);

        // Test 1: clean 0xA5 frame.
        base = done_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, BIT);
        wait_clk(300);
        check("t1_pulses", 32'(done_cnt - base), 32'd1);
        check_frame("t1", 8'hA5, 1'b0);
        check("t1_busy", 32'(bus.busy_o), 32'h0);
        check("t1_held", 32'(bus.data_o), 32'hA5);

        // Test 2: 4-tick low glitch is rejected at mid start bit.
        base = done_cnt;
        bus.rx_i = 1'b0;
        wait_clk(4 * TICKDIV);
        bus.rx_i = 1'b1;
        wait_clk(100);
        check("t2_busy_mid", 32'(bus.busy_o), 32'h1);
        wait_clk(1000);
        check("t2_pulses", 32'(done_cnt - base), 32'd0);
        check("t2_busy", 32'(bus.busy_o), 32'h0);
        check("t2_held", 32'(bus.data_o), 32'hA5);

        // Test 3: stop bit low -> framing error.
        base = done_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, BADSTOP);
        wait_clk(600);
        check("t3_pulses", 32'(done_cnt - base), 32'd1);
        check_frame("t3", 8'h5A, 1'b1);
        check("t3_busy", 32'(bus.busy_o), 32'h0);

        // Test 4: back-to-back 0x00 then 0xFF, no idle gap.
        base = done_cnt;
        send_frame(8'h00, 1'b1, 1'b0, BIT);
        send_frame(8'hFF, 1'b1, 1'b0, BIT);
        wait_clk(300);
        check("t4_pulses", 32'(done_cnt - base), 32'd2);
        if (done_cnt - base >= 2) begin
            check("t4_data0", 32'(rec_data[base]), 32'h00);
            check("t4_ferr0", 32'(rec_ferr[base]), 32'h0);
        end
        check_frame("t4b", 8'hFF, 1'b0);

        // Test 5: reset during data bit 4 of 0x11, then 0x3C.
        base = done_cnt;
        bus.rx_i = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            bus.rx_i = (i == 0) ? 1'b1 : 1'b0;
            wait_clk(BIT);
        end
        bus.rx_i = 1'b1;
        wait_clk(500);
        reset_i = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        wait_clk(3);
        reset_i = 1'b1;
        wait_clk(2000);
        check("t5_nopulse", 32'(done_cnt - base), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, BIT);
        wait_clk(300);
        check("t5_pulses", 32'(done_cnt - base), 32'd1);
        check_frame("t5", 8'h3C, 1'b0);

        // Randomised frame: random byte and random stop-bit validity.
        base  = done_cnt;
        rd    = 8'($urandom);
        rstop = 1'($urandom_range(1, 0));
        wait_clk($urandom_range(150, 20));
        send_frame(rd, rstop, ^rd, rstop ? BIT : BADSTOP);
        wait_clk(600);
        check("rnd_pulses", 32'(done_cnt - base), 32'd1);
        check_frame("rnd", rd, ~rstop);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x01 needs parity bit 1.
        send_frame(8'h01, 1'b1, 1'b1, BIT);
        wait_clk(300);
        check("t6_good_perr", 32'(rec_perr[$]), 32'h0);
        check("t6_good_data", 32'(rec_data[$]), 32'h01);
        send_frame(8'h01, 1'b1, 1'b0, BIT);
        wait_clk(300);
        check("t6_bad_perr", 32'(rec_perr[$]), 32'h1);
        check("t6_bad_data", 32'(rec_data[$]), 32'h01);
`endif

        check("long_pulses", 32'(long_cnt), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
